// File: rtl/pc_field_unit.sv
// pc_field_unit: PDP-8 PC with IF/DF/IB/SF field registers; define PCU_USER_MODE_EN to add time-share user mode (UF/UB).
module pc_field_unit #(
  parameter int ADDR_W = 12,
  parameter int FIELD_W = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'o0200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       skip,
  input  logic                       irq_override,
  input  logic                       ck_fetch,
  input  logic                       latch,
  input  logic                       cdf_wr,
  input  logic                       cif_wr,
  input  logic [FIELD_W-1:0]         field_in,
  input  logic                       irq_ack,
  input  logic                       rmf,
`ifdef PCU_USER_MODE_EN
  input  logic                       cuf,
  input  logic                       suf,
  output logic                       uf_out,
  output logic                       ub_out,
  output logic [2*FIELD_W:0]         sf_out,
`else
  output logic [2*FIELD_W-1:0]       sf_out,
`endif
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_lat,
  output logic [FIELD_W-1:0]         if_out,
  output logic [FIELD_W-1:0]         df_out,
  output logic [FIELD_W-1:0]         ib_out,
  output logic [ADDR_W+FIELD_W-1:0]  ext_addr,
  output logic                       int_inhibit
);
  logic load_q, load_edge, eff_inc, set_inh;
  logic [ADDR_W-1:0] step, pc_n;
  logic [FIELD_W-1:0] if_n, df_n, ib_n;
  logic [$bits(sf_out)-1:0] sf_n;
  logic inh_n;
`ifdef PCU_USER_MODE_EN
  logic uf_n, ub_n;
  assign set_inh = cif_wr | rmf | suf;
  always_comb begin
    uf_n = irq_ack ? 1'b0 : load_edge ? ub_out : uf_out;
    ub_n = irq_ack ? 1'b0 : suf ? 1'b1 : cuf ? 1'b0 : rmf ? sf_out[2*FIELD_W] : ub_out;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      uf_out <= 1'b0;
      ub_out <= 1'b0;
    end else begin
      uf_out <= uf_n;
      ub_out <= ub_n;
    end
  end
  assign sf_n = irq_ack ? {uf_out, if_out, df_out} : sf_out;
`else
  assign set_inh = cif_wr | rmf;
  assign sf_n = irq_ack ? {if_out, df_out} : sf_out;
`endif
  assign load_edge = load & ~load_q;
  assign eff_inc = inc & ~(irq_override & ck_fetch);
  assign step = skip ? ADDR_W'(2) : ADDR_W'(1);
  assign ext_addr = {if_out, pc};
  always_comb begin
    pc_n = irq_ack ? pc : load_edge ? in : eff_inc ? pc + step : pc;
    if_n = irq_ack ? '0 : load_edge ? ib_out : if_out;
    df_n = irq_ack ? '0 : rmf ? sf_out[FIELD_W-1:0] : cdf_wr ? field_in : df_out;
    ib_n = irq_ack ? '0 : cif_wr ? field_in : rmf ? sf_out[2*FIELD_W-1:FIELD_W] : ib_out;
    inh_n = irq_ack ? 1'b0 : set_inh ? 1'b1 : load_edge ? 1'b0 : int_inhibit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q <= 1'b1;
      pc <= RESET_PC;
      pc_lat <= RESET_PC;
      if_out <= '0;
      df_out <= '0;
      ib_out <= '0;
      sf_out <= '0;
      int_inhibit <= 1'b0;
    end else begin
      load_q <= load;
      pc <= pc_n;
      pc_lat <= latch ? pc : pc_lat;
      if_out <= if_n;
      df_out <= df_n;
      ib_out <= ib_n;
      sf_out <= sf_n;
      int_inhibit <= inh_n;
    end
  end
endmodule

// File: tb/tb_pc_field_unit.sv
// tb_pc_field_unit: directed scoreboard bench for pc_field_unit; stimulus queues expectations, negedge monitor checks them.
module tb_pc_field_unit;
  logic clk = 0, reset, load, inc, skip, irq_override, ck_fetch, latch, cdf_wr, cif_wr, irq_ack, rmf;
  logic [11:0] in, pc, pc_lat;
  logic [2:0] field_in, if_out, df_out, ib_out;
  logic [14:0] ext_addr;
  logic int_inhibit;
`ifdef PCU_USER_MODE_EN
  logic cuf = 0, suf = 0, uf_out, ub_out;
  logic [6:0] sf_out;
`else
  logic [5:0] sf_out;
`endif
  typedef struct { string name; int sel; int val; } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  pc_field_unit dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .skip(skip),
    .irq_override(irq_override), .ck_fetch(ck_fetch), .latch(latch),
    .cdf_wr(cdf_wr), .cif_wr(cif_wr), .field_in(field_in), .irq_ack(irq_ack), .rmf(rmf),
`ifdef PCU_USER_MODE_EN
    .cuf(cuf), .suf(suf), .uf_out(uf_out), .ub_out(ub_out),
`endif
    .pc(pc), .pc_lat(pc_lat), .if_out(if_out), .df_out(df_out), .ib_out(ib_out),
    .sf_out(sf_out), .ext_addr(ext_addr), .int_inhibit(int_inhibit)
  );
  function automatic int dut_val(int sel);
    case (sel)
      0: return int'(pc);
      1: return int'(pc_lat);
      2: return int'(if_out);
      3: return int'(df_out);
      4: return int'(ib_out);
      5: return int'(sf_out);
      6: return int'(int_inhibit);
      default: return int'(ext_addr);
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      int got;
      e = q.pop_front();
      got = dut_val(e.sel);
      total++;
      if (got == e.val) passed++;
      else $display("FAIL %s: got %0o expected %0o", e.name, got, e.val);
    end
  task automatic expect_v(string name, int sel, int val);
    q.push_back('{name, sel, val});
  endtask
  task automatic check(string name, int got, int val);
    total++;
    if (got == val) passed++;
    else $display("FAIL %s: got %0o expected %0o (direct)", name, got, val);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; load = 1; in = 12'o5555; inc = 0; skip = 0; irq_override = 0; ck_fetch = 0;
    latch = 0; cdf_wr = 0; cif_wr = 0; field_in = 0; irq_ack = 0; rmf = 0;
    tick; tick;
    reset = 0;
    tick;
    check("rst_pc", int'(pc), 'o0200); check("rst_pc_lat", int'(pc_lat), 'o0200);
    check("rst_if", int'(if_out), 0); check("rst_df", int'(df_out), 0);
    check("rst_ib", int'(ib_out), 0); check("rst_sf", int'(sf_out), 0);
    check("rst_inh", int'(int_inhibit), 0); check("rst_ext", int'(ext_addr), 'o00200);
    load = 0; cif_wr = 1; field_in = 1;
    tick;
    expect_v("cif1_ib", 4, 1); expect_v("cif1_inh", 6, 1); expect_v("cif1_if", 2, 0);
    cif_wr = 0; load = 1; in = 12'o7776;
    tick;
    expect_v("jmp7776_pc", 0, 'o7776); expect_v("jmp7776_if", 2, 1); expect_v("jmp7776_inh", 6, 0);
    load = 0; inc = 1; skip = 1;
    tick;
    expect_v("wrap_pc", 0, 'o0000); expect_v("wrap_if", 2, 1); expect_v("wrap_ext", 7, 'o10000);
    skip = 0;
    tick;
    expect_v("inc1_pc", 0, 'o0001);
    inc = 0; cif_wr = 1; field_in = 5;
    tick;
    expect_v("cif5_ib", 4, 5); expect_v("cif5_inh", 6, 1); expect_v("cif5_if", 2, 1);
    cif_wr = 0; load = 1; in = 12'o1234;
    tick;
    expect_v("jmp1234_pc", 0, 'o1234); expect_v("jmp1234_if", 2, 5);
    expect_v("jmp1234_ext", 7, 'o51234); expect_v("jmp1234_inh", 6, 0);
    in = 12'o4000;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("load_held_pc", int'(pc), 'o1234);
    end
    load = 0; cif_wr = 1; cdf_wr = 1; field_in = 3;
    tick;
    cdf_wr = 1; cif_wr = 0; field_in = 6;
    tick;
    expect_v("setup_ib", 4, 3); expect_v("setup_df", 3, 6);
    cdf_wr = 0; load = 1; in = 12'o0100;
    tick;
    expect_v("jmp0100_if", 2, 3);
    load = 0; irq_ack = 1; cdf_wr = 1; field_in = 7;
    tick;
    expect_v("irq_sf", 5, 'o36); expect_v("irq_if", 2, 0); expect_v("irq_df", 3, 0);
    expect_v("irq_ib", 4, 0); expect_v("irq_pc", 0, 'o0100); expect_v("irq_inh", 6, 0);
    irq_ack = 0; field_in = 2;
    tick;
    expect_v("cdf2_df", 3, 2);
    cdf_wr = 0; rmf = 1;
    tick;
    expect_v("rmf_ib", 4, 3); expect_v("rmf_df", 3, 6); expect_v("rmf_inh", 6, 1);
    rmf = 0; load = 1; in = 12'o0300;
    tick;
    expect_v("jmp0300_if", 2, 3); expect_v("jmp0300_pc", 0, 'o0300); expect_v("jmp0300_inh", 6, 0);
    load = 0; inc = 1; irq_override = 1; ck_fetch = 1;
    tick;
    expect_v("ovr_pc", 0, 'o0300);
    irq_override = 0; ck_fetch = 0; latch = 1;
    tick;
    expect_v("latch_pc", 0, 'o0301); expect_v("latch_pc_lat", 1, 'o0300);
    latch = 0; irq_override = 1;
    tick;
    expect_v("ovr_nofetch_pc", 0, 'o0302); expect_v("hold_pc_lat", 1, 'o0300);
    inc = 0; irq_override = 0; cif_wr = 1; field_in = 2;
    tick;
    expect_v("cif2_ib", 4, 2);
    load = 1; in = 12'o0400; field_in = 4;
    tick;
    expect_v("same_if", 2, 2); expect_v("same_ib", 4, 4); expect_v("same_inh", 6, 1);
    expect_v("same_pc", 0, 'o0400);
    load = 0; cif_wr = 1; rmf = 1; cdf_wr = 1; field_in = 7;
    tick;
    expect_v("prio_ib", 4, 7); expect_v("prio_df", 3, 6); expect_v("prio_inh", 6, 1);
    cif_wr = 0; rmf = 0; cdf_wr = 0; load = 1; in = 12'o0500; inc = 1;
    tick;
    expect_v("load_over_inc_pc", 0, 'o0500); expect_v("load_over_inc_if", 2, 7);
    load = 0; inc = 0; latch = 1; reset = 1;
    tick;
    expect_v("rst2_pc", 0, 'o0200); expect_v("rst2_pc_lat", 1, 'o0200); expect_v("rst2_if", 2, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_field_unit.md
Name: pc_field_unit

Overview:
Parametrised program-counter unit with PDP-8 style memory-extension field registers. It holds the PC, Instruction Field (IF), Data Field (DF), Instruction Buffer (IB) and Save Field (SF), and produces the extended fetch address {IF,PC}. CIF defers a field change until the next jump, and interrupts are inhibited until that jump. The unit sits between the instruction decoder/sequencer and the memory address mux.

Parameters:
ADDR_W, 12, PC width in bits.
FIELD_W, 3, field register width; address space is 2^(ADDR_W+FIELD_W).
RESET_PC, 12'o0200, PC value loaded on reset; must fit in ADDR_W bits.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high.
in  input  ADDR_W  jump target.
load  input  1  jump request; acts only on its rising edge.
inc  input  1  PC increment request.
skip  input  1  with inc: add 2 instead of 1; ignored without inc.
irq_override  input  1  interrupt entry in progress.
ck_fetch  input  1  fetch-phase strobe.
latch  input  1  copy pc into pc_lat.
cdf_wr  input  1  DF <= field_in.
cif_wr  input  1  IB <= field_in; sets int_inhibit.
field_in  input  FIELD_W  field operand from the IOT word.
irq_ack  input  1  interrupt entry: save IF/DF into SF, clear fields.
rmf  input  1  restore from SF: IB <= SF.if, DF <= SF.df; sets int_inhibit.
pc  output  ADDR_W  current PC.
pc_lat  output  ADDR_W  latched PC.
if_out  output  FIELD_W  instruction field.
df_out  output  FIELD_W  data field.
ib_out  output  FIELD_W  instruction buffer.
sf_out  output  2*FIELD_W  save field, {IF,DF}.
ext_addr  output  ADDR_W+FIELD_W  {if_out,pc}, combinational.
int_inhibit  output  1  high while a field change is pending; the interrupt controller must not grant while it is high.

Behaviour:
- Reset: pc = pc_lat = RESET_PC; IF = DF = IB = SF = 0; int_inhibit = 0; the load edge detector is cleared, so a load held high through reset does not fire on the first cycle after reset.
- load_edge = load & ~load_q. load_q is a register updated every non-reset cycle.
- eff_inc = inc & ~(irq_override & ck_fetch).
- PC priority, highest first, one action per cycle:
  - reset
  - irq_ack: pc unchanged; the sequencer loads the vector via load.
  - load_edge: pc <= in.
  - eff_inc: pc <= pc + (skip ? 2 : 1), modulo 2^ADDR_W. IF is never changed on wrap (0o7777 + 1 -> 0o0000, same field).
- Field registers, same cycle as the above:
  - irq_ack: SF <= {IF,DF}; IF, DF, IB <= 0; int_inhibit <= 0. irq_ack overrides cdf_wr, cif_wr and rmf in the same cycle.
  - Otherwise, on load_edge: IF <= IB; int_inhibit <= 0.
  - cdf_wr: DF <= field_in.
  - cif_wr: IB <= field_in; int_inhibit <= 1.
  - rmf: IB <= SF[2F-1:F]; DF <= SF[F-1:0]; int_inhibit <= 1.
  - cif_wr has priority over rmf for IB. rmf has priority over cdf_wr for DF.
  - cif_wr or rmf coinciding with load_edge: IF takes the old IB, the new IB is written, and int_inhibit ends at 1. The new field waits for the next jump.
- latch: pc_lat <= pc, using the pre-update value, evaluated independently of all other operations; reset wins.
- Latency: every register updates 1 cycle after its strobe; outputs are registered except ext_addr.

Optional Feature:
Macro PCU_USER_MODE_EN adds time-share user mode.
- Added ports:
  - cuf (clear UB), input 1.
  - suf (set UB, int_inhibit <= 1), input 1.
  - uf_out, output 1.
  - ub_out, output 1.
- With the macro:
  - UF <= UB on load_edge.
  - irq_ack: UF, UB <= 0 and SF gains MSB = UF, so sf_out is 2*FIELD_W+1 wide.
  - rmf: UB <= SF MSB.
  - suf has priority over cuf.
  - Reset: UF = UB = 0.
- Without the macro: these ports and registers do not exist and sf_out is 2*FIELD_W wide.

Test Plan:
- Reset, then release -> pc=0o0200, pc_lat=0o0200, all fields 0, int_inhibit=0; hold load=1 through reset -> pc stays 0o0200.
- pc=0o7776, inc=1, skip=1 -> pc=0o0000, if_out unchanged; next inc with skip=0 -> 0o0001.
- cif_wr, field_in=5 -> ib_out=5, int_inhibit=1, if_out=0; then load rising with in=0o1234 -> pc=0o1234, if_out=5, ext_addr=0o51234, int_inhibit=0; load held high 3 more cycles -> no further load.
- IF=3, DF=6, irq_ack -> sf_out=0o36, if/df/ib=0; cdf_wr 2 -> df_out=2; rmf -> ib_out=3, df_out=6, int_inhibit=1; load edge -> if_out=3.
- inc=1 with irq_override=1, ck_fetch=1 -> pc holds; latch together with inc -> pc_lat = pre-increment pc.
- Same-cycle load edge and cif_wr=4 with IB=2 -> if_out=2, ib_out=4, int_inhibit=1.
